// File: rtl/msrv32_dm_store_buffer.sv
// Posted-write buffer between the msrv32 store unit and the AHB-lite data bus.
// Queues up to DEPTH masked word writes and retires them as non-pipelined AHB writes.
module msrv32_dm_store_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        st_wr_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [31:0] st_data_in,
  input  logic [3:0]  st_mask_in,
  output logic        st_ready_out,
  output logic        buf_empty_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  output logic [3:0]  hwstrb_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic        err_out,
  output logic [31:0] err_addr_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  logic            alive_q, alive_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [3:0]      hwstrb_q, hwstrb_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          head;
  logic [1:0]      head_lsb;
  logic [2:0]      head_size;
  logic [31:0]     head_haddr;
  logic            unused_addr_lsb;

  always_comb unused_addr_lsb = ^st_addr_in[1:0];

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // alive_q keeps ready low for the whole reset window, even after pointers clear
    st_ready_out = alive_q && !full;
    push  = st_wr_req_in && st_ready_out && (st_mask_in != 4'b0000);
    pop   = (state_q == S_DATA) && hready_in;
    head  = fifo_q[rd_ptr_q[AW-1:0]];
    buf_empty_out = empty && (state_q == S_IDLE);
  end

  // Transfer size and low address bits derived from the head byte mask
  always_comb begin
    head_lsb  = 2'd0;
    head_size = 3'b010;
    case (head.mask)
      4'b0001: begin head_lsb = 2'd0; head_size = 3'b000; end
      4'b0010: begin head_lsb = 2'd1; head_size = 3'b000; end
      4'b0100: begin head_lsb = 2'd2; head_size = 3'b000; end
      4'b1000: begin head_lsb = 2'd3; head_size = 3'b000; end
      4'b0011: begin head_lsb = 2'd0; head_size = 3'b001; end
      4'b1100: begin head_lsb = 2'd2; head_size = 3'b001; end
      default: ;
    endcase
    head_haddr = {head.addr, head_lsb};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (push ? PTR_ONE : '0);
    rd_ptr_d   = rd_ptr_q + (pop  ? PTR_ONE : '0);
    alive_d    = 1'b1;
    fifo_d     = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = '{addr: st_addr_in[31:2], data: st_data_in, mask: st_mask_in};
    end
    hwdata_d   = hwdata_q;
    hwstrb_d   = hwstrb_q;
    if ((state_q == S_ADDR) && hready_in) begin
      hwdata_d = head.data;
      hwstrb_d = head.mask;
    end
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if ((state_q == S_DATA) && hresp_in) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = head_haddr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_ADDR;
      S_ADDR: if (hready_in) state_d = S_DATA;
      // Post-pop occupancy (including a same-cycle push) decides whether to start another address phase
      S_DATA: if (hready_in) state_d = (wr_ptr_d != rd_ptr_d) ? S_ADDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    htrans_out = 2'b00;
    hwrite_out = 1'b0;
    haddr_out  = '0;
    hsize_out  = 3'b000;
    case (state_q)
      S_ADDR: begin
        htrans_out = 2'b10;
        hwrite_out = 1'b1;
        haddr_out  = head_haddr;
        hsize_out  = head_size;
      end
      S_DATA: begin
        haddr_out  = head_haddr;
        hsize_out  = head_size;
      end
      default: ;
    endcase
    hwdata_out   = hwdata_q;
    hwstrb_out   = hwstrb_q;
    err_out      = err_q;
    err_addr_out = err_addr_q;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      alive_q    <= 1'b0;
      hwdata_q   <= '0;
      hwstrb_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      alive_q    <= alive_d;
      hwdata_q   <= hwdata_d;
      hwstrb_q   <= hwstrb_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_msrv32_dm_store_buffer.sv
// Self-checking bench for msrv32_dm_store_buffer: directed scenarios plus a
// randomized run against a transaction-level queue model of the bus protocol.
module tb_msrv32_dm_store_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_wr_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic        buf_empty;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  logic        hresp;
  logic        err;
  logic [31:0] err_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  msrv32_dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .st_wr_req_in         (st_wr_req),
    .st_addr_in           (st_addr),
    .st_data_in           (st_data),
    .st_mask_in           (st_mask),
    .st_ready_out         (st_ready),
    .buf_empty_out        (buf_empty),
    .haddr_out            (haddr),
    .htrans_out           (htrans),
    .hwrite_out           (hwrite),
    .hsize_out            (hsize),
    .hwdata_out           (hwdata),
    .hwstrb_out           (hwstrb),
    .hready_in            (hready),
    .hresp_in             (hresp),
    .err_out              (err),
    .err_addr_out         (err_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected low address bits for a byte mask
  function automatic logic [1:0] exp_lsb(input logic [3:0] m);
    if ($countones(m) == 1) begin
      for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
    end
    if (m == 4'b1100) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_size(input logic [3:0] m);
    if ($countones(m) == 1) return 3'b000;
    if (m == 4'b0011 || m == 4'b1100) return 3'b001;
    return 3'b010;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; st_wr_req = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    hready = 1'b1; hresp = 1'b0;
    step(); step();
    n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL reset_htrans got %h exp 0", htrans); end
    n_cmp++; if (hwrite !== 1'b0) begin n_bad++; $display("FAIL reset_hwrite got %b exp 0", hwrite); end
    n_cmp++; if (haddr !== 32'h0) begin n_bad++; $display("FAIL reset_haddr got %h exp 0", haddr); end
    n_cmp++; if (hsize !== 3'b000) begin n_bad++; $display("FAIL reset_hsize got %b exp 000", hsize); end
    n_cmp++; if (hwdata !== 32'h0) begin n_bad++; $display("FAIL reset_hwdata got %h exp 0", hwdata); end
    n_cmp++; if (hwstrb !== 4'h0) begin n_bad++; $display("FAIL reset_hwstrb got %b exp 0", hwstrb); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
    n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL reset_buf_empty got %b exp 1", buf_empty); end
    n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_during got %b exp 0", st_ready); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got %b exp 1", st_ready); end
  endtask

  task automatic test_single_word();
    hready = 1'b1;
    st_wr_req = 1'b1; st_addr = 32'h0000_1004; st_data = 32'hDEAD_BEEF; st_mask = 4'b1111;
    step();
    st_wr_req = 1'b0;
    n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL word_n_htrans got %h exp 0", htrans); end
    n_cmp++; if (buf_empty !== 1'b0) begin n_bad++; $display("FAIL word_n_empty got %b exp 0", buf_empty); end
    step();
    n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL word_n1_htrans got %h exp 2", htrans); end
    n_cmp++; if (hwrite !== 1'b1) begin n_bad++; $display("FAIL word_n1_hwrite got %b exp 1", hwrite); end
    n_cmp++; if (haddr !== 32'h0000_1004) begin n_bad++; $display("FAIL word_n1_haddr got %h exp 1004", haddr); end
    n_cmp++; if (hsize !== 3'b010) begin n_bad++; $display("FAIL word_n1_hsize got %b exp 010", hsize); end
    step();
    n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL word_n2_htrans got %h exp 0", htrans); end
    n_cmp++; if (hwrite !== 1'b0) begin n_bad++; $display("FAIL word_n2_hwrite got %b exp 0", hwrite); end
    n_cmp++; if (hwdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_n2_hwdata got %h exp deadbeef", hwdata); end
    n_cmp++; if (hwstrb !== 4'b1111) begin n_bad++; $display("FAIL word_n2_hwstrb got %b exp 1111", hwstrb); end
    n_cmp++; if (buf_empty !== 1'b0) begin n_bad++; $display("FAIL word_n2_empty got %b exp 0", buf_empty); end
    step();
    n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL word_n3_empty got %b exp 1", buf_empty); end
  endtask

  task automatic test_byte_half();
    logic [3:0]  masks [2];
    logic [2:0]  sizes [2];
    masks[0] = 4'b0100; sizes[0] = 3'b000;
    masks[1] = 4'b1100; sizes[1] = 3'b001;
    hready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st_wr_req = 1'b1; st_addr = 32'h0000_0020; st_data = 32'h00AB_0000; st_mask = masks[k];
      step();
      st_wr_req = 1'b0;
      step();
      n_cmp++; if (htrans !== 2'b10) begin n_bad++; $display("FAIL bh%0d_htrans got %h exp 2", k, htrans); end
      n_cmp++; if (haddr !== 32'h0000_0022) begin n_bad++; $display("FAIL bh%0d_haddr got %h exp 22", k, haddr); end
      n_cmp++; if (hsize !== sizes[k]) begin n_bad++; $display("FAIL bh%0d_hsize got %b exp %b", k, hsize, sizes[k]); end
      step();
      n_cmp++; if (hwstrb !== masks[k]) begin n_bad++; $display("FAIL bh%0d_hwstrb got %b exp %b", k, hwstrb, masks[k]); end
      n_cmp++; if (hwdata !== 32'h00AB_0000) begin n_bad++; $display("FAIL bh%0d_hwdata got %h exp 00ab0000", k, hwdata); end
      step();
      n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL bh%0d_empty got %b exp 1", k, buf_empty); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen [$];
    logic [31:0] expa [3];
    logic        take;
    int          c;
    expa[0] = 32'h100; expa[1] = 32'h104; expa[2] = 32'h108;
    hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_wr_req = 1'b1; st_addr = expa[k]; st_data = 32'h1111_1111 * (k + 1); st_mask = 4'b1111;
      n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_push%0d got %b exp 1", k, st_ready); end
      step();
    end
    st_addr = expa[2]; st_data = 32'h3333_3333;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full%0d got %b exp 0", k, st_ready); end
      step();
    end
    hready = 1'b1;
    c = 0;
    while (c < 40 && !(st_wr_req == 1'b0 && buf_empty == 1'b1)) begin
      if (htrans == 2'b10 && hready) seen.push_back(haddr);
      take = st_wr_req && st_ready;
      step();
      c++;
      if (take) st_wr_req = 1'b0;
    end
    n_cmp++; if (c >= 40) begin n_bad++; $display("FAIL b2b_drain_timeout got %0d cycles exp <40", c); end
    n_cmp++; if (seen.size() != 3) begin n_bad++; $display("FAIL b2b_count got %0d exp 3", seen.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < seen.size()) begin
        n_cmp++; if (seen[k] !== expa[k]) begin n_bad++; $display("FAIL b2b_order%0d got %h exp %h", k, seen[k], expa[k]); end
      end
    end
  endtask

  task automatic test_error();
    int c;
    int unsigned ntr;
    hready = 1'b1; hresp = 1'b1;
    st_wr_req = 1'b1; st_addr = 32'h40; st_data = 32'hA5A5_0040; st_mask = 4'b1111;
    step();
    st_addr = 32'h80; st_data = 32'hA5A5_0080;
    step();
    st_wr_req = 1'b0;
    c = 0; ntr = 0;
    while (c < 20 && !buf_empty) begin
      if (htrans == 2'b10) ntr++;
      step();
      c++;
    end
    hresp = 1'b0;
    n_cmp++; if (c >= 20) begin n_bad++; $display("FAIL err_drain_timeout got %0d cycles exp <20", c); end
    n_cmp++; if (ntr != 2) begin n_bad++; $display("FAIL err_transfers got %0d exp 2", ntr); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_flag got %b exp 1", err); end
    n_cmp++; if (err_addr !== 32'h40) begin n_bad++; $display("FAIL err_addr got %h exp 40", err_addr); end
  endtask

  task automatic test_reset_mid();
    int c;
    hready = 1'b0; hresp = 1'b0;
    st_wr_req = 1'b1; st_addr = 32'h200; st_data = 32'h0000_0200; st_mask = 4'b1111;
    step();
    st_addr = 32'h204; st_data = 32'h0000_0204;
    step();
    st_wr_req = 1'b0;
    c = 0;
    while (c < 10 && htrans != 2'b10) begin step(); c++; end
    n_cmp++; if (c >= 10) begin n_bad++; $display("FAIL rmid_addr_timeout got %0d cycles exp <10", c); end
    hready = 1'b1;
    step();
    hready = 1'b0;
    n_cmp++; if (hwdata !== 32'h0000_0200) begin n_bad++; $display("FAIL rmid_data_phase got %h exp 200", hwdata); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL rmid_htrans got %h exp 0", htrans); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty got %b exp 1", buf_empty); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b exp 0", err); end
    n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_during got %b exp 0", st_ready); end
    rst_n = 1'b1;
    hready = 1'b1;
    step();
    n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b exp 1", st_ready); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL rmid_quiet%0d got %h exp 0", k, htrans); end
      step();
    end
  endtask

  task automatic test_mask_zero();
    hready = 1'b1;
    st_wr_req = 1'b1; st_addr = 32'h300; st_data = 32'hFFFF_FFFF; st_mask = 4'b0000;
    step();
    st_wr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (htrans !== 2'b00) begin n_bad++; $display("FAIL mz_htrans%0d got %h exp 0", k, htrans); end
      n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL mz_empty%0d got %b exp 1", k, buf_empty); end
      step();
    end
  endtask

  // Transaction-level model: queue of accepted writes plus the bus phase we expect to see.
  task automatic test_random();
    wr_t         q [$];
    wr_t         w;
    int          phase;   // 0 idle, 1 address phase, 2 data phase
    logic        merr;
    logic [31:0] merr_addr;
    logic        acc;
    rst_n = 1'b0; st_wr_req = 1'b0; hready = 1'b1; hresp = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    phase = 0; merr = 1'b0; merr_addr = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_cmp++; if (htrans !== ((phase == 1) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL rnd_htrans c%0d got %h phase %0d", cyc, htrans, phase); end
      n_cmp++; if (hwrite !== (phase == 1)) begin n_bad++; $display("FAIL rnd_hwrite c%0d got %b phase %0d", cyc, hwrite, phase); end
      if (phase == 0) begin
        n_cmp++; if (haddr !== 32'h0) begin n_bad++; $display("FAIL rnd_idle_haddr c%0d got %h exp 0", cyc, haddr); end
      end
      if (phase == 1 && q.size() > 0) begin
        n_cmp++; if (haddr !== {q[0].addr[31:2], exp_lsb(q[0].mask)}) begin n_bad++; $display("FAIL rnd_haddr c%0d got %h exp %h", cyc, haddr, {q[0].addr[31:2], exp_lsb(q[0].mask)}); end
        n_cmp++; if (hsize !== exp_size(q[0].mask)) begin n_bad++; $display("FAIL rnd_hsize c%0d got %b exp %b", cyc, hsize, exp_size(q[0].mask)); end
      end
      if (phase == 2 && q.size() > 0) begin
        n_cmp++; if (hwdata !== q[0].data) begin n_bad++; $display("FAIL rnd_hwdata c%0d got %h exp %h", cyc, hwdata, q[0].data); end
        n_cmp++; if (hwstrb !== q[0].mask) begin n_bad++; $display("FAIL rnd_hwstrb c%0d got %b exp %b", cyc, hwstrb, q[0].mask); end
      end
      n_cmp++; if (st_ready !== (q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, st_ready, q.size() < DEPTH); end
      n_cmp++; if (buf_empty !== (q.size() == 0 && phase == 0)) begin n_bad++; $display("FAIL rnd_empty c%0d got %b exp %b", cyc, buf_empty, q.size() == 0 && phase == 0); end
      n_cmp++; if (err !== merr) begin n_bad++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, err, merr); end
      n_cmp++; if (err_addr !== merr_addr) begin n_bad++; $display("FAIL rnd_err_addr c%0d got %h exp %h", cyc, err_addr, merr_addr); end

      st_wr_req = (cyc < 1400) && ($urandom % 3 != 0);
      st_addr   = $urandom;
      st_data   = $urandom;
      st_mask   = 4'($urandom % 16);
      hready    = ($urandom % 4 != 0);
      hresp     = ($urandom % 8 == 0);

      acc = st_wr_req && (q.size() < DEPTH) && (st_mask != 4'b0000);
      case (phase)
        0: if (q.size() > 0) phase = 1;
        1: if (hready) phase = 2;
        default: begin
          if (hresp) begin
            if (!merr) merr_addr = {q[0].addr[31:2], exp_lsb(q[0].mask)};
            merr = 1'b1;
          end
          if (hready) begin
            void'(q.pop_front());
            phase = ((q.size() + (acc ? 1 : 0)) > 0) ? 1 : 0;
          end
        end
      endcase
      if (acc) begin
        w.addr = st_addr; w.data = st_data; w.mask = st_mask;
        q.push_back(w);
      end
      step();
    end
    st_wr_req = 1'b0; hresp = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_model_drain got %0d entries exp 0", q.size()); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL rnd_final_empty got %b exp 1", buf_empty); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_byte_half();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_mask_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
